cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: s_line, 256, cache line width in bits for all line data buses.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_read  input  1  I-cache line fill request.
REQ-005 i_addr  input  32  I-cache line address; bits [4:0] are zero.
REQ-006 i_rdata  output  s_line  line returned to the I-cache.
REQ-007 i_resp  output  1  one-cycle completion pulse to the I-cache.
REQ-008 d_read  input  1  D-cache line fill request.
REQ-009 d_write  input  1  D-cache line writeback request.
REQ-010 d_addr  input  32  D-cache line address.
REQ-011 d_wdata  input  s_line  D-cache writeback line.
REQ-012 d_rdata  output  s_line  line returned to the D-cache.
REQ-013 d_resp  output  1  one-cycle completion pulse to the D-cache.
REQ-014 mem_read, mem_write  output  1 each  physical memory commands.
REQ-015 mem_addr  output  32; mem_wdata  output  s_line  memory address and write line.
REQ-016 mem_rdata  input  s_line; mem_resp  input  1  memory read line and completion.

Function
REQ-017 The arbiter SHALL run an FSM with states IDLE, SERVE_I, SERVE_D and RESP.
REQ-018 IDLE: if only i_read is high, go to SERVE_I; if only d_read or d_write is high, go to SERVE_D; otherwise stay.
REQ-019 IDLE, both clients requesting: grant the client not recorded in last_grant (round-robin); after reset last_grant = I, so D wins the first tie.
REQ-020 On grant, latch address, command and (for D writes) wdata into internal registers; memory outputs SHALL be driven only from these registers.
REQ-021 SERVE_x: hold mem_read/mem_write, mem_addr and mem_wdata stable until mem_resp is sampled high.
REQ-022 On mem_resp in SERVE_x: capture mem_rdata into the line buffer, update last_grant, and go to RESP.
REQ-023 RESP: assert exactly one cycle of i_resp or d_resp to the granted client, with i_rdata/d_rdata equal to the line buffer; then go to IDLE.
REQ-024 Latency: mem_resp in cycle N gives client resp in cycle N+1; the earliest new grant is in cycle N+2.
REQ-025 A client SHALL NOT receive resp in the same cycle as mem_resp, and never both i_resp and d_resp at once.
REQ-026 If d_read and d_write are both high, d_write takes precedence (writeback before fill).
REQ-027 Request lines in RESP are ignored; a request still high in IDLE is treated as new.
REQ-028 i_rdata and d_rdata SHALL both continuously show the line buffer; only resp distinguishes the owner.
REQ-029 mem_read and mem_write SHALL never be high together, and are both low outside SERVE_x.

Reset
REQ-030 Asserting rst at any time, including mid-transaction, forces state IDLE, mem_read = mem_write = 0, i_resp = d_resp = 0, last_grant = I, and the latched address, wdata and line buffer to 0, without waiting for a clock edge.
REQ-031 An abandoned memory transaction is not resumed; a mem_resp arriving in IDLE is ignored.

Structure
REQ-032 The FSM state enum (arb_state_t) and the s_line default SHALL live in the shared cache types package.
REQ-033 No sub-module is required; the arbiter is a single FSM plus datapath registers.

Verification
REQ-034 I read only, addr 0x0000_0060, mem_resp after 3 cycles with rdata = {8{32'hA5A5A5A5}} -> i_resp one cycle later with that line; d_resp stays 0.
REQ-035 D write, addr 0x0000_1000, wdata = {8{32'h1234_5678}} -> mem_write high with stable addr and data until mem_resp, then d_resp for 1 cycle.
REQ-036 i_read and d_read rise in the same cycle out of reset -> D served first, then I; repeat the tie -> I served first.
REQ-037 d_read and d_write both high -> mem_write issued, never mem_read.
REQ-038 rst asserted during SERVE_I while waiting for mem_resp -> mem_read drops immediately; a late mem_resp produces no i_resp.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// rtl/cache_arbiter_pkg.sv - shared cache types: arbiter states, grant owner, line width default
package cache_arbiter_pkg;

    localparam int S_LINE_DEFAULT = 256;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2,
        ARB_RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// rtl/cache_arbiter_if.sv - I-cache, D-cache and memory buses of the cache arbiter
interface cache_arbiter_if
    import cache_arbiter_pkg::*;
#(
    parameter int s_line = S_LINE_DEFAULT
);
    logic              i_read;
    logic [31:0]       i_addr;
    logic [s_line-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [31:0]       d_addr;
    logic [s_line-1:0] d_wdata;
    logic [s_line-1:0] d_rdata;
    logic              d_resp;

    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_addr;
    logic [s_line-1:0] mem_wdata;
    logic [s_line-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin arbiter sharing one memory port between I- and D-cache
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int s_line = S_LINE_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    cache_arbiter_if.slave bus
);
    arb_state_t        state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [31:0]       addr_q, addr_d;
    logic [s_line-1:0] wdata_q, wdata_d;
    logic [s_line-1:0] line_q, line_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GRANT_I;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            line_q       <= line_d;
        end
    end

    always_comb begin
        logic i_req, d_req, grant_i, grant_d;
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        line_d       = line_q;
        i_req        = bus.i_read;
        d_req        = bus.d_read | bus.d_write;
        grant_i      = 1'b0;
        grant_d      = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                // On a tie the client that did not win last time goes next
                if (i_req && d_req) begin
                    grant_d = (last_grant_q == GRANT_I);
                    grant_i = (last_grant_q == GRANT_D);
                end else begin
                    grant_i = i_req;
                    grant_d = d_req;
                end
                if (grant_i) begin
                    state_d     = ARB_SERVE_I;
                    addr_d      = bus.i_addr;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                end
                if (grant_d) begin
                    state_d     = ARB_SERVE_D;
                    addr_d      = bus.d_addr;
                    mem_read_d  = ~bus.d_write;
                    mem_write_d = bus.d_write;
                    if (bus.d_write) begin
                        wdata_d = bus.d_wdata;
                    end
                end
            end
            ARB_SERVE_I, ARB_SERVE_D: begin
                if (bus.mem_resp) begin
                    line_d       = bus.mem_rdata;
                    last_grant_d = (state_q == ARB_SERVE_D) ? GRANT_D : GRANT_I;
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    state_d      = ARB_RESP;
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // last_grant already names the owner of the transaction completing in RESP
    assign bus.i_resp    = (state_q == ARB_RESP) && (last_grant_q == GRANT_I);
    assign bus.d_resp    = (state_q == ARB_RESP) && (last_grant_q == GRANT_D);
    assign bus.i_rdata   = line_q;
    assign bus.d_rdata   = line_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed self-checking bench for cache_arbiter
module tb_cache_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    cache_arbiter_if #(.s_line(256)) bus ();

    cache_arbiter #(.s_line(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] LINE_A5 = {8{32'hA5A5A5A5}};
    localparam logic [255:0] LINE_12 = {8{32'h12345678}};
    localparam logic [255:0] LINE_C3 = {8{32'hC3C3C3C3}};
    localparam logic [255:0] LINE_5A = {8{32'h5A5A5A5A}};

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one cycle after the grant edge; completes the transaction and ends in IDLE
    task automatic serve(input int lat, input logic [255:0] rd, input logic exp_wr,
                         input logic [31:0] exp_addr, input logic [255:0] exp_wd,
                         input logic exp_d);
        for (int k = 0; k < lat; k++) begin
            check("mem_read_hold", bus.mem_read, !exp_wr);
            check("mem_write_hold", bus.mem_write, exp_wr);
            check("mem_addr_hold", bus.mem_addr, exp_addr);
            if (exp_wr) check("mem_wdata_hold", bus.mem_wdata, exp_wd);
            check("no_resp_wait", {bus.i_resp, bus.d_resp}, 2'b00);
            step();
        end
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = rd;
        #1;
        check("no_resp_with_mem_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        step();
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        check("i_resp", bus.i_resp, !exp_d);
        check("d_resp", bus.d_resp, exp_d);
        check("i_rdata", bus.i_rdata, rd);
        check("d_rdata", bus.d_rdata, rd);
        check("mem_cmd_after_resp", {bus.mem_read, bus.mem_write}, 2'b00);
        step();
        check("resp_one_cycle", {bus.i_resp, bus.d_resp}, 2'b00);
        check("mem_cmd_idle", {bus.mem_read, bus.mem_write}, 2'b00);
    endtask

    initial begin
        bus.i_read = 0; bus.i_addr = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0; bus.mem_resp = 0;
        #1;
        check("rst_mem_cmd", {bus.mem_read, bus.mem_write}, 2'b00);
        check("rst_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        check("rst_rdata", bus.i_rdata, '0);
        check("rst_addr", bus.mem_addr, '0);
        step(); step();
        rst = 1'b0;
        step();

        // I read only
        bus.i_read = 1; bus.i_addr = 32'h0000_0060;
        step();
        bus.i_read = 0;
        serve(3, LINE_A5, 1'b0, 32'h0000_0060, '0, 1'b0);

        // D write
        bus.d_write = 1; bus.d_addr = 32'h0000_1000; bus.d_wdata = LINE_12;
        step();
        bus.d_write = 0; bus.d_wdata = '0; bus.d_addr = 32'hFFFF_FFE0;
        serve(4, LINE_C3, 1'b1, 32'h0000_1000, LINE_12, 1'b1);

        // Fresh reset, then a held tie: D first, then I on the repeated tie
        rst = 1'b1; #1; rst = 1'b0;
        step();
        bus.i_read = 1; bus.i_addr = 32'h0000_0200;
        bus.d_read = 1; bus.d_addr = 32'h0000_0400;
        step();
        check("tie1_d_first", bus.mem_addr, 32'h0000_0400);
        serve(1, LINE_5A, 1'b0, 32'h0000_0400, '0, 1'b1);
        step();
        check("tie2_i_granted", bus.mem_addr, 32'h0000_0200);
        bus.i_read = 0; bus.d_read = 0;
        serve(2, LINE_A5, 1'b0, 32'h0000_0200, '0, 1'b0);

        // d_read and d_write together: writeback wins
        bus.d_read = 1; bus.d_write = 1; bus.d_addr = 32'h0000_0800; bus.d_wdata = LINE_C3;
        step();
        bus.d_read = 0; bus.d_write = 0;
        serve(2, LINE_12, 1'b1, 32'h0000_0800, LINE_C3, 1'b1);

        // Reset mid-transaction, late mem_resp ignored
        bus.i_read = 1; bus.i_addr = 32'h0000_0060;
        step();
        bus.i_read = 0;
        check("abort_mem_read_up", bus.mem_read, 1'b1);
        step();
        #2;
        rst = 1'b1;
        #1;
        check("abort_mem_read_drop", bus.mem_read, 1'b0);
        check("abort_line_cleared", bus.i_rdata, '0);
        check("abort_addr_cleared", bus.mem_addr, '0);
        step();
        rst = 1'b0;
        bus.mem_resp = 1'b1; bus.mem_rdata = LINE_A5;
        step();
        bus.mem_resp = 1'b0; bus.mem_rdata = '0;
        check("late_resp_no_i_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        check("late_resp_no_cmd", {bus.mem_read, bus.mem_write}, 2'b00);
        step();
        check("late_resp_still_idle", {bus.i_resp, bus.d_resp}, 2'b00);
        check("late_resp_line_zero", bus.d_rdata, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule
